// File: rtl/dff_readout_sequencer.sv
// dff_readout_sequencer: runs one readout frame of the DFF error-count
// serializer. The frame is a capture strobe, a serializer clear, then
// NUM_CHAINS*BITS_PER_CHAIN enabled shift clocks, with the valid window
// flagged to the link. Frames start on a start_req rising edge or when the
// auto-trigger interval timer expires.
// Optional build macro READOUT_HEADER_EN inserts a 16-bit HEADER_WORD,
// sent LSB first, ahead of the payload.
module dff_readout_sequencer #(
    parameter int          NUM_CHAINS     = 20,
    parameter int          BITS_PER_CHAIN = 16,
    parameter int          INTERVAL_W     = 24,
    parameter int          SAVE_WIDTH     = 2,
    parameter logic [15:0] HEADER_WORD    = 16'hA5C3
) (
    input  logic                  data_clk,
    input  logic                  reset,
    input  logic                  start_req,
    input  logic                  auto_en,
    input  logic [INTERVAL_W-1:0] interval,
    input  logic                  overrun_clr,
    input  logic                  ser_data_in,
    output logic                  save_data,
    output logic                  ser_reset,
    output logic                  ser_clk_en,
    output logic                  tx_data,
    output logic                  frame_valid,
    output logic [8:0]            bit_index,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun,
    output logic [15:0]           frame_count
);

    localparam int TOTAL = NUM_CHAINS * BITS_PER_CHAIN;
`ifdef READOUT_HEADER_EN
    localparam int HDR_LEN = 16;
`else
    localparam int HDR_LEN = 0;
`endif
    localparam int CNT_W = $clog2(TOTAL + 16);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAVE,
        S_SETTLE,
        S_HEADER,
        S_CLEAR,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_nxt;
    logic [INTERVAL_W-1:0]   timer;
    logic                    start_prev;
    logic                    start_edge;
    logic                    timer_armed;
    logic                    timer_fire;
    logic                    timer_pend;
    logic                    trigger;
    logic                    overrun_set;

    // Trigger decode. The timer "fires" on the cycle its decrement reaches 0;
    // afterwards it sits at 0 as a pending request until a frame consumes it.
    always_comb begin
        start_edge  = start_req & ~start_prev;
        timer_armed = auto_en && (interval != '0);
        timer_fire  = timer_armed && (timer == INTERVAL_W'(1));
        timer_pend  = timer_armed && (timer == '0);
        trigger     = start_edge | timer_fire | timer_pend;
        overrun_set = (state != S_IDLE) && (start_edge || timer_fire);
    end

    // Previous start_req sample for edge detection; tracks through reset so a
    // request held high across reset does not fire a frame.
    always_ff @(posedge data_clk) begin
        start_prev <= start_req;
    end

    // State register and per-state cycle counter.
    always_ff @(posedge data_clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic; the counter restarts at 0 on every state change.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (trigger) state_nxt = S_SAVE;
            S_SAVE:   if (cnt == CNT_W'(SAVE_WIDTH - 1)) state_nxt = S_SETTLE;
`ifdef READOUT_HEADER_EN
            S_SETTLE: state_nxt = S_HEADER;
            S_HEADER: if (cnt == CNT_W'(HDR_LEN - 1)) state_nxt = S_CLEAR;
`else
            S_SETTLE: state_nxt = S_CLEAR;
`endif
            S_CLEAR:  state_nxt = S_SHIFT;
            S_SHIFT:  if (cnt == CNT_W'(TOTAL - 1)) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if ((state_nxt != state) || (state == S_IDLE)) begin
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    // Frame outputs. Serializer data lags its enabled clock by one cycle, so
    // the valid window runs from the 2nd SHIFT cycle through DONE.
    always_comb begin
        save_data   = 1'b0;
        ser_reset   = reset;
        ser_clk_en  = reset;
        frame_valid = 1'b0;
        tx_data     = 1'b0;
        bit_index   = '0;
        done        = 1'b0;
        busy        = (state != S_IDLE);
        case (state)
            S_SAVE: save_data = 1'b1;
`ifdef READOUT_HEADER_EN
            S_HEADER: begin
                frame_valid = 1'b1;
                tx_data     = HEADER_WORD[cnt[3:0]];
                bit_index   = 9'(cnt);
            end
`endif
            S_CLEAR: begin
                ser_reset  = 1'b1;
                ser_clk_en = 1'b1;
            end
            S_SHIFT: begin
                ser_clk_en = 1'b1;
                if (cnt != '0) begin
                    frame_valid = 1'b1;
                    tx_data     = ser_data_in;
                    bit_index   = 9'(HDR_LEN + int'(cnt) - 1);
                end
            end
            S_DONE: begin
                done        = 1'b1;
                frame_valid = 1'b1;
                tx_data     = ser_data_in;
                bit_index   = 9'(HDR_LEN + TOTAL - 1);
            end
            default: ;
        endcase
    end

    // Interval timer: reloads on frame start and whenever auto triggering is
    // off, otherwise counts down and holds at 0 until consumed.
    always_ff @(posedge data_clk) begin
        if (reset) begin
            timer <= interval;
        end else if (!auto_en || ((state == S_IDLE) && trigger)) begin
            timer <= interval;
        end else if (timer != '0) begin
            timer <= timer - INTERVAL_W'(1);
        end
    end

    // Sticky overrun flag; a new event wins over a simultaneous clear.
    always_ff @(posedge data_clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (overrun_set) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

    // Completed-frame counter, wrapping at 16 bits.
    always_ff @(posedge data_clk) begin
        if (reset) begin
            frame_count <= '0;
        end else if (state == S_DONE) begin
            frame_count <= frame_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_dff_readout_sequencer.sv
// Testbench for dff_readout_sequencer: a serializer model feeds the DUT,
// expected frames (start cycle and bit stream) are queued by the stimulus,
// and a monitor checks each frame the DUT presents against the queue.
module tb_dff_readout_sequencer;

    localparam int TOTAL = 320;
`ifdef READOUT_HEADER_EN
    localparam int HDR = 16;
`else
    localparam int HDR = 0;
`endif
    localparam int FR_BITS  = HDR + TOTAL;
    localparam int BUSY_LEN = 2 + 1 + HDR + 1 + TOTAL + 1;
    localparam int P_MIN    = BUSY_LEN + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_req = 1'b0;
    logic        auto_en = 1'b0;
    logic [23:0] interval = '0;
    logic        overrun_clr = 1'b0;
    logic        ser_q;
    logic        save_data, ser_reset, ser_clk_en, tx_data, frame_valid;
    logic [8:0]  bit_index;
    logic        busy, done, overrun;
    logic [15:0] frame_count;

    dff_readout_sequencer dut (
        .data_clk(clk), .reset(reset), .start_req(start_req), .auto_en(auto_en),
        .interval(interval), .overrun_clr(overrun_clr), .ser_data_in(ser_q),
        .save_data(save_data), .ser_reset(ser_reset), .ser_clk_en(ser_clk_en),
        .tx_data(tx_data), .frame_valid(frame_valid), .bit_index(bit_index),
        .busy(busy), .done(done), .overrun(overrun), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;
    int exp_done = 0;
    int done_seen = 0;
    int viol = 0;
    logic [15:0] fc_model = '0;
    logic [15:0] hword = 16'hA5C3;
    logic [15:0] chains [20];

    typedef struct {
        int                 start;
        logic [FR_BITS-1:0] bits;
    } rec_t;
    rec_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Payload order: chain 0 first, each chain LSB first.
    function automatic logic [TOTAL-1:0] payload();
        logic [TOTAL-1:0] v;
        for (int c = 0; c < 20; c++)
            for (int b = 0; b < 16; b++)
                v[c*16+b] = chains[c][b];
        return v;
    endfunction

    function automatic logic [FR_BITS-1:0] expect_frame();
        logic [FR_BITS-1:0] e;
        for (int i = 0; i < HDR; i++) e[i] = hword[i];
        e[FR_BITS-1:HDR] = payload();
        return e;
    endfunction

    task automatic push_frame(input int start, input bit completes);
        rec_t r;
        r.start = start;
        r.bits  = expect_frame();
        exp_q.push_back(r);
        if (completes) begin
            exp_done++;
            fc_model++;
        end
    endtask

    // Serializer model: capture on save_data, clear on clocked ser_reset,
    // one bit out per enabled clock, visible the cycle after.
    logic [TOTAL-1:0] ser_shadow;
    int ser_ptr = 0;
    always @(posedge clk) begin
        if (save_data === 1'b1) ser_shadow <= payload();
        if (ser_clk_en === 1'b1) begin
            if (ser_reset) begin
                ser_ptr <= 0;
                ser_q   <= 1'b0;
            end else begin
                ser_q   <= (ser_ptr < TOTAL) ? ser_shadow[ser_ptr] : 1'b0;
                ser_ptr <= ser_ptr + 1;
            end
        end
    end

    // Monitor: pops an expected frame at each busy rise and checks it.
    rec_t cur;
    logic [FR_BITS-1:0] got;
    logic [15:0] mon_fc = '0;
    bit busy_prev = 0, in_frame = 0, fc_pend = 0;
    int busy_cnt, save_cnt, rst_cnt, clk_cnt, valid_cnt, idx_err;
    always @(negedge clk) begin
        if (reset) begin
            in_frame  = 0;
            busy_prev = 0;
            fc_pend   = 0;
            mon_fc    = '0;
        end else begin
            if (fc_pend) begin
                chk("frame_count_after_done", frame_count, mon_fc);
                fc_pend = 0;
            end
            if (busy && !busy_prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_frame: got a frame at cycle %0d, expected none", cyc);
                    cur.start = -1;
                    cur.bits  = '0;
                end else begin
                    cur = exp_q.pop_front();
                    if (cyc != cur.start) begin
                        errors++;
                        $display("FAIL frame_start: got cycle %0d, expected cycle %0d", cyc, cur.start);
                    end
                end
                in_frame = 1;
                busy_cnt = 0; save_cnt = 0; rst_cnt = 0; clk_cnt = 0;
                valid_cnt = 0; idx_err = 0; got = '0;
            end
            if (!busy && busy_prev && in_frame) begin
                chk("busy_length", busy_cnt, BUSY_LEN);
                in_frame = 0;
            end
            if (busy) begin
                busy_cnt++;
                if (save_data) save_cnt++;
                if (ser_reset) rst_cnt++;
                if (ser_clk_en) clk_cnt++;
            end else if (save_data || ser_reset || ser_clk_en) begin
                viol++;
            end
            if (frame_valid) begin
                if (bit_index != 9'(valid_cnt)) idx_err++;
                if (valid_cnt < FR_BITS) got[valid_cnt] = tx_data;
                valid_cnt++;
            end else if (bit_index != 0 || tx_data) begin
                viol++;
            end
            if (done) begin
                done_seen++;
                chk("valid_cycles", valid_cnt, FR_BITS);
                chk("bit_index_seq_errors", idx_err, 0);
                chk("save_width", save_cnt, 2);
                chk("ser_reset_cycles", rst_cnt, 1);
                chk("ser_clk_en_cycles", clk_cnt, TOTAL + 1);
                checks++;
                if (got !== cur.bits) begin
                    errors++;
                    $display("FAIL frame_data: got %h, expected %h", got, cur.bits);
                end
                mon_fc  = mon_fc + 16'd1;
                fc_pend = 1;
            end
            busy_prev = busy;
        end
    end

    initial begin
        int c, s, t;
        // Reset values
        goto(3);
        chk("rst_save_data", save_data, 0);
        chk("rst_ser_reset", ser_reset, 1);
        chk("rst_ser_clk_en", ser_clk_en, 1);
        chk("rst_frame_valid", frame_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_bit_index", bit_index, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_frame_count", frame_count, 0);
        goto(5);
        reset = 1'b0;
        goto(6);
        chk("idle_ser_reset", ser_reset, 0);
        chk("idle_ser_clk_en", ser_clk_en, 0);

        // Manual frames: fixed corner pattern first, then random contents;
        // odd frames also get a dropped start edge while busy.
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 20; k++) chains[k] = (f == 0) ? 16'h0 : 16'($urandom);
            if (f == 0) begin
                chains[0]  = 16'h0001;
                chains[19] = 16'h8000;
            end
            c = cyc + int'($urandom_range(3, 40));
            goto(c);
            start_req = 1'b1;
            push_frame(c + 1, 1);
            goto(c + 1);
            start_req = 1'b0;
            if (f % 2 == 1) begin
                t = c + 1 + int'($urandom_range(5, 250));
                goto(t);
                start_req = 1'b1;
                goto(t + 1);
                start_req = 1'b0;
                goto(t + 2);
                chk("overrun_busy_edge", overrun, 1);
                overrun_clr = 1'b1;
                goto(t + 3);
                overrun_clr = 1'b0;
                goto(t + 4);
                chk("overrun_clr", overrun, 0);
            end
            goto(c + 1 + BUSY_LEN + 2);
            chk("frame_count_manual", frame_count, fc_model);
        end

        // Auto trigger, interval longer than a frame
        for (int k = 0; k < 20; k++) chains[k] = 16'($urandom);
        interval = 24'd1000;
        c = cyc + 2;
        goto(c);
        auto_en = 1'b1;
        for (int k = 1; k <= 5; k++) push_frame(c + 1000 * k, 1);
        goto(c + 5400);
        auto_en = 1'b0;
        chk("auto1000_overrun", overrun, 0);
        chk("auto1000_frame_count", frame_count, fc_model);

        // Auto trigger, interval shorter than a frame: deferred starts
        interval = 24'd200;
        c = cyc + 2;
        goto(c);
        auto_en = 1'b1;
        for (int k = 0; k < 4; k++) push_frame(c + 200 + k * P_MIN, 1);
        goto(c + 450);
        chk("auto200_overrun_set", overrun, 1);
        goto(c + 460);
        overrun_clr = 1'b1;
        goto(c + 461);
        overrun_clr = 1'b0;
        goto(c + 470);
        chk("auto200_overrun_cleared", overrun, 0);
        goto(c + 200 + P_MIN + 250);
        chk("auto200_overrun_reset", overrun, 1);
        goto(c + 200 + 3 * P_MIN + 50);
        auto_en = 1'b0;
        goto(c + 200 + 4 * P_MIN + 5);
        chk("auto200_frame_count", frame_count, fc_model);

        // Start edge mid-frame, then reset mid-frame
        overrun_clr = 1'b1;
        goto(cyc + 1);
        overrun_clr = 1'b0;
        goto(cyc + 1);
        chk("pre_abort_overrun", overrun, 0);
        for (int k = 0; k < 20; k++) chains[k] = 16'($urandom);
        c = cyc + 3;
        goto(c);
        start_req = 1'b1;
        s = c + 1;
        push_frame(s, 0);
        goto(c + 1);
        start_req = 1'b0;
        goto(s + 105);
        chk("bit_index_at_edge", bit_index, 100);
        start_req = 1'b1;
        goto(s + 106);
        start_req = 1'b0;
        goto(s + 107);
        chk("abort_overrun_set", overrun, 1);
        goto(s + 155);
        chk("bit_index_at_reset", bit_index, 150);
        reset = 1'b1;
        fc_model = '0;
        goto(s + 156);
        chk("abort_busy", busy, 0);
        chk("abort_frame_valid", frame_valid, 0);
        chk("abort_bit_index", bit_index, 0);
        chk("abort_save_data", save_data, 0);
        chk("abort_ser_reset", ser_reset, 1);
        chk("abort_ser_clk_en", ser_clk_en, 1);
        chk("abort_done", done, 0);
        chk("abort_overrun", overrun, 0);
        chk("abort_frame_count", frame_count, 0);
        goto(s + 158);
        reset = 1'b0;
        goto(s + 400);

        // Recovery frame after reset
        c = cyc + 5;
        goto(c);
        start_req = 1'b1;
        push_frame(c + 1, 1);
        goto(c + 1);
        start_req = 1'b0;
        goto(c + 1 + BUSY_LEN + 2);
        chk("recovery_frame_count", frame_count, fc_model);

        chk("frames_left_in_queue", exp_q.size(), 0);
        chk("done_pulses", done_seen, exp_done);
        chk("idle_output_violations", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
